// File: rtl/counter_pkg.sv
// Shared CSR address map, mcountinhibit bit indices and address decode helper
// for the performance-counter block.
package counter_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int CY_BIT = 0;
  localparam int IR_BIT = 1;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MCYCLE,
    SEL_MCYCLEH,
    SEL_MINSTRET,
    SEL_MINSTRETH,
    SEL_CYCLE,
    SEL_CYCLEH,
    SEL_INSTRET,
    SEL_INSTRETH,
    SEL_INHIBIT
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(input logic [11:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_MCYCLE:        sel = SEL_MCYCLE;
      CSR_MCYCLEH:       sel = SEL_MCYCLEH;
      CSR_MINSTRET:      sel = SEL_MINSTRET;
      CSR_MINSTRETH:     sel = SEL_MINSTRETH;
      CSR_CYCLE:         sel = SEL_CYCLE;
      CSR_CYCLEH:        sel = SEL_CYCLEH;
      CSR_INSTRET:       sel = SEL_INSTRET;
      CSR_INSTRETH:      sel = SEL_INSTRETH;
      CSR_MCOUNTINHIBIT: sel = SEL_INHIBIT;
      default:           sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic is_alias(input csr_sel_e sel);
    return (sel == SEL_CYCLE) || (sel == SEL_CYCLEH) ||
           (sel == SEL_INSTRET) || (sel == SEL_INSTRETH);
  endfunction

endpackage

// File: rtl/counter_ctrl_counter.sv
// One counter half: write beats increment; carry flags an increment out of all-ones.
module counter_ctrl_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] wd,
  input  logic         enable,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset)       q <= '0;
    else if (we)     q <= wd;
    else if (enable) q <= q + ONE;
  end

  // A write overrides the increment, so no carry leaves this half that cycle.
  assign carry = enable && !we && (&q);

endmodule

// File: rtl/counter_ctrl_reg.sv
// Plain W-bit register with synchronous reset to RST_VAL and write enable.
module counter_ctrl_reg #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] wd,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RST_VAL;
    else if (we) q <= wd;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Cycle/instret counters with CSR access; mcountinhibit exists only when
// COUNTER_INHIBIT_EN is defined, otherwise 0x320 reads 0 and counting is free-running.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter logic [1:0] INHIBIT_RST = 2'b00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            retire,
  input  logic [11:0]     csr_addr,
  input  logic            csr_we,
  input  logic [XLEN-1:0] csr_wd,
  output logic [XLEN-1:0] csr_rd,
  output logic            csr_hit,
  output logic            csr_illegal
);

  csr_sel_e        sel;
  logic [1:0]      inhibit;
  logic [XLEN-1:0] cycle_lo, cycle_hi, instret_lo, instret_hi;
  logic            cycle_carry, instret_carry;
  logic            unused_cycle_wrap, unused_instret_wrap;

  assign sel = csr_decode(csr_addr);

`ifdef COUNTER_INHIBIT_EN
  counter_ctrl_reg #(.W(2), .RST_VAL(INHIBIT_RST)) u_inhibit (
    .clk   (clk),
    .reset (reset),
    .we    (csr_we && (sel == SEL_INHIBIT)),
    .wd    (csr_wd[1:0]),
    .q     (inhibit)
  );
`else
  logic unused_inhibit_rst;
  assign unused_inhibit_rst = ^INHIBIT_RST;
  assign inhibit = 2'b00;
`endif

  counter_ctrl_counter #(.W(XLEN)) u_cycle_lo (
    .clk    (clk),
    .reset  (reset),
    .we     (csr_we && (sel == SEL_MCYCLE)),
    .wd     (csr_wd),
    .enable (!inhibit[CY_BIT]),
    .q      (cycle_lo),
    .carry  (cycle_carry)
  );

  counter_ctrl_counter #(.W(XLEN)) u_cycle_hi (
    .clk    (clk),
    .reset  (reset),
    .we     (csr_we && (sel == SEL_MCYCLEH)),
    .wd     (csr_wd),
    .enable (cycle_carry),
    .q      (cycle_hi),
    .carry  (unused_cycle_wrap)
  );

  counter_ctrl_counter #(.W(XLEN)) u_instret_lo (
    .clk    (clk),
    .reset  (reset),
    .we     (csr_we && (sel == SEL_MINSTRET)),
    .wd     (csr_wd),
    .enable (retire && !inhibit[IR_BIT]),
    .q      (instret_lo),
    .carry  (instret_carry)
  );

  counter_ctrl_counter #(.W(XLEN)) u_instret_hi (
    .clk    (clk),
    .reset  (reset),
    .we     (csr_we && (sel == SEL_MINSTRETH)),
    .wd     (csr_wd),
    .enable (instret_carry),
    .q      (instret_hi),
    .carry  (unused_instret_wrap)
  );

  always_comb begin
    csr_rd  = '0;
    csr_hit = 1'b1;
    case (sel)
      SEL_MCYCLE,    SEL_CYCLE:    csr_rd = cycle_lo;
      SEL_MCYCLEH,   SEL_CYCLEH:   csr_rd = cycle_hi;
      SEL_MINSTRET,  SEL_INSTRET:  csr_rd = instret_lo;
      SEL_MINSTRETH, SEL_INSTRETH: csr_rd = instret_hi;
      SEL_INHIBIT:                 csr_rd = XLEN'(inhibit);
      default:                     csr_hit = 1'b0;
    endcase
  end

  assign csr_illegal = csr_we && is_alias(sel);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl; expectations adapt to COUNTER_INHIBIT_EN.
module tb_counter_ctrl;

  localparam int XLEN = 32;
  localparam logic [1:0] INH_RST = 2'b10;
`ifdef COUNTER_INHIBIT_EN
  localparam logic [31:0] EXP_INH_RST = 32'd2;
`else
  localparam logic [31:0] EXP_INH_RST = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            reset, retire, csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wd, csr_rd;
  logic            csr_hit, csr_illegal;
  int              errors = 0;
  int              checks = 0;

  counter_ctrl #(.XLEN(XLEN), .INHIBIT_RST(INH_RST)) dut (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .csr_addr    (csr_addr),
    .csr_we      (csr_we),
    .csr_wd      (csr_wd),
    .csr_rd      (csr_rd),
    .csr_hit     (csr_hit),
    .csr_illegal (csr_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_we   = 1'b0;
    csr_addr = a;
    #1;
    chk(tag, csr_rd, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a;
    csr_wd   = d;
    csr_we   = 1'b1;
    tick();
    csr_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; retire = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wd = '0;
    tick();
    tick();
    rd_chk("rst_mcycle", 12'hB00, 32'h0);
    rd_chk("rst_mcycleh", 12'hB80, 32'h0);
    rd_chk("rst_minstret", 12'hB02, 32'h0);
    rd_chk("rst_inhibit", 12'h320, EXP_INH_RST);
    chk("rst_inhibit_hit", 32'(csr_hit), 32'd1);
    reset = 1'b0;
    tick();
    rd_chk("count_1", 12'hB00, 32'h1);
    tick();
    rd_chk("count_2_alias", 12'hC00, 32'h2);
    chk("alias_rd_not_illegal", 32'(csr_illegal), 32'd0);

    // low-to-high carry
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFE);
    rd_chk("carry_pre", 12'hB00, 32'hFFFF_FFFE);
    tick();
    tick();
    rd_chk("carry_lo", 12'hB00, 32'h0);
    rd_chk("carry_hi", 12'hB80, 32'h1);

    // high write beats carry; low still wraps
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h5);
    rd_chk("coll_lo", 12'hB00, 32'h0);
    rd_chk("coll_hi", 12'hB80, 32'h5);
    tick();
    rd_chk("coll_lo_next", 12'hB00, 32'h1);
    rd_chk("coll_hi_next", 12'hB80, 32'h5);

    // low write beats increment, no carry
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB00, 32'h10);
    rd_chk("lowwr_lo", 12'hB00, 32'h10);
    rd_chk("lowwr_hi", 12'hB80, 32'h5);

    // full 64-bit wrap
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_chk("wrap_lo", 12'hB00, 32'h0);
    rd_chk("wrap_hi", 12'hB80, 32'h0);

    // read-only alias write and unmapped address
    wr(12'hB00, 32'h100);
    csr_addr = 12'hC00; csr_wd = 32'hDEAD_BEEF; csr_we = 1'b1;
    #1;
    chk("alias_illegal", 32'(csr_illegal), 32'd1);
    chk("alias_hit", 32'(csr_hit), 32'd1);
    chk("alias_rd", csr_rd, 32'h100);
    tick();
    csr_we = 1'b0;
    rd_chk("alias_no_effect", 12'hB00, 32'h101);
    chk("rw_no_illegal", 32'(csr_illegal), 32'd0);
    csr_addr = 12'h123; csr_wd = 32'hFFFF_FFFF; csr_we = 1'b1;
    #1;
    chk("unmapped_hit", 32'(csr_hit), 32'd0);
    chk("unmapped_rd", csr_rd, 32'h0);
    chk("unmapped_illegal", 32'(csr_illegal), 32'd0);
    tick();
    csr_we = 1'b0;
    rd_chk("unmapped_no_effect", 12'hB00, 32'h102);

`ifdef COUNTER_INHIBIT_EN
    // IR inhibited from reset: retires are ignored
    retire = 1'b1;
    repeat (10) tick();
    rd_chk("ir_inhibited", 12'hB02, 32'h0);
    wr(12'h320, 32'h0);
    rd_chk("ir_write_cycle_old", 12'hB02, 32'h0);
    repeat (3) tick();
    retire = 1'b0;
    rd_chk("ir_enabled_3", 12'hB02, 32'h3);
    rd_chk("ir_alias_3", 12'hC02, 32'h3);

    // CY inhibit takes effect after the write cycle
    wr(12'hB00, 32'h1000);
    wr(12'h320, 32'h1);
    rd_chk("cy_write_cycle_counts", 12'hB00, 32'h1001);
    tick();
    rd_chk("cy_inhibited", 12'hB00, 32'h1001);
    rd_chk("inhibit_rd_1", 12'h320, 32'h1);
    wr(12'h320, 32'hFFFF_FFFF);
    rd_chk("inhibit_rsvd_zero", 12'h320, 32'h3);
    rd_chk("cy_still_inhibited", 12'hB00, 32'h1001);
    wr(12'h320, 32'h0);
    rd_chk("cy_clear_cycle_old", 12'hB00, 32'h1001);
    tick();
    rd_chk("cy_resumed", 12'hB00, 32'h1002);
`else
    // no inhibit register: retires count straight after reset
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    rd_chk("ir_free_3", 12'hB02, 32'h3);
    rd_chk("ir_alias_3", 12'hC02, 32'h3);

    wr(12'hB00, 32'h1000);
    wr(12'h320, 32'h3);
    rd_chk("inhibit_reads_zero", 12'h320, 32'h0);
    chk("inhibit_hit", 32'(csr_hit), 32'd1);
    rd_chk("cy_free_write_cycle", 12'hB00, 32'h1001);
    tick();
    rd_chk("cy_free_next", 12'hB00, 32'h1002);
`endif

    // instret carry into high half
    wr(12'hB02, 32'hFFFF_FFFF);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    rd_chk("ir_carry_lo", 12'hB02, 32'h0);
    rd_chk("ir_carry_hi", 12'hB82, 32'h1);
    rd_chk("ir_carry_alias_hi", 12'hC82, 32'h1);

    // reset mid-count discards a pending write and retire
    wr(12'hB80, 32'h1);
    wr(12'hB00, 32'h5);
    rd_chk("pre_rst_lo", 12'hB00, 32'h5);
    rd_chk("pre_rst_hi", 12'hB80, 32'h1);
    reset = 1'b1; retire = 1'b1;
    csr_addr = 12'hB00; csr_wd = 32'h55; csr_we = 1'b1;
    tick();
    reset = 1'b0; retire = 1'b0; csr_we = 1'b0;
    rd_chk("midrst_mcycle", 12'hB00, 32'h0);
    rd_chk("midrst_mcycleh", 12'hB80, 32'h0);
    rd_chk("midrst_minstret", 12'hB02, 32'h0);
    rd_chk("midrst_minstreth", 12'hB82, 32'h0);
    rd_chk("midrst_inhibit", 12'h320, EXP_INH_RST);
    tick();
    rd_chk("post_rst_count", 12'hB00, 32'h1);
    rd_chk("post_rst_instret", 12'hB02, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the CSR data width and the width of each counter half.
REQ-002 SHALL have parameter INHIBIT_RST, default 2'b00, meaning the mcountinhibit value loaded at reset: bit0 = CY, bit1 = IR.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port retire, input, 1, one instruction retires this cycle.
REQ-006 SHALL have port csr_addr, input, 12, the CSR address.
REQ-007 SHALL have port csr_we, input, 1, the CSR write strobe.
REQ-008 SHALL have port csr_wd, input, XLEN, the CSR write data.
REQ-009 SHALL have port csr_rd, output, XLEN, the CSR read data.
REQ-010 SHALL have port csr_hit, output, 1, csr_addr decodes to a register in this block.
REQ-011 SHALL have port csr_illegal, output, 1, a write was attempted to a read-only alias.

Function
REQ-012 SHALL hold two 2*XLEN-bit counters, cycle and instret, each split into a low and a high XLEN half.
REQ-013 SHALL decode addresses as follows:
- 0xB00/0xB80: mcycle/mcycleh, read-write.
- 0xB02/0xB82: minstret/minstreth, read-write.
- 0xC00/0xC80/0xC02/0xC82: cycle/cycleh/instret/instreth, read-only aliases.
- 0x320: mcountinhibit, bits [1:0] writable, other bits read 0.
REQ-014 SHALL make csr_rd, csr_hit and csr_illegal combinational from csr_addr/csr_we, showing the pre-edge register value (zero-latency read, no read-during-write bypass).
REQ-015 SHALL drive csr_rd=0 and csr_hit=0 for unmapped addresses, and ignore writes to them.
REQ-016 SHALL assert csr_illegal when csr_we=1 and csr_addr is a 0xCxx alias; the write has no effect.
REQ-017 SHALL increment the cycle low half every cycle when CY inhibit=0.
REQ-018 SHALL increment the instret low half when retire=1 and IR inhibit=0.
REQ-019 SHALL increment a high half exactly when its low half increments from all-ones, wrapping to 0.
REQ-020 SHALL wrap the full 2*XLEN counter from all-ones to 0 silently.
REQ-021 SHALL give a CSR write to a low half priority over its increment in that cycle; no carry is produced that cycle.
REQ-022 SHALL give a CSR write to a high half priority over any carry into it in that cycle, so the carry is lost; the low half still increments normally.
REQ-023 SHALL apply an mcountinhibit write from the next cycle onward; counting in the write cycle follows the old inhibit value.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, clear all four counter halves to 0 and load mcountinhibit with INHIBIT_RST.
REQ-025 SHALL, on reset mid-count, discard any pending carry and CSR write in that cycle.
REQ-026 SHALL not count in the cycle reset is asserted.
REQ-027 SHALL keep csr_rd combinational during reset.

Configuration
REQ-028 SHALL, with COUNTER_INHIBIT_EN defined, implement mcountinhibit as in REQ-013/023/024.
REQ-029 SHALL, without COUNTER_INHIBIT_EN:
- make 0x320 read 0 with csr_hit=1;
- ignore writes to 0x320;
- make both counters count unconditionally;
- ignore INHIBIT_RST.

Structure
REQ-030 SHALL take from shared package counter_pkg:
- the CSR address constants;
- the mcountinhibit bit indices CY_BIT=0 and IR_BIT=1.
REQ-031 SHALL build each of the four halves from an instance of the existing counter sub-module, using its we/wd/enable inputs for write and increment.
REQ-032 SHALL implement the mcountinhibit register with the existing register module.

Verification
REQ-033 SHALL cover carry: write mcycle=0xFFFF_FFFE, mcycleh=0 -> after 2 cycles mcycle=0, mcycleh=1.
REQ-034 SHALL cover write/carry collision: mcycle=0xFFFF_FFFF, write mcycleh=0x5 in the same cycle -> next cycle mcycleh=0x5, mcycle=0.
REQ-035 SHALL cover retire gating: IR inhibit=1, retire=1 for 10 cycles -> minstret unchanged; then inhibit=0, 3 retires -> minstret +3.
REQ-036 SHALL cover read-only aliases: write 0xC00 -> csr_illegal=1, mcycle keeps counting; write 0x123 -> csr_hit=0, csr_rd=0.
REQ-037 SHALL cover reset mid-count: cycle=0x1_0000_0005, assert reset 1 cycle -> all counters 0, mcountinhibit=INHIBIT_RST.
REQ-038 SHALL cover the macro: build without COUNTER_INHIBIT_EN, write 0x320=3 -> reads 0 and cycle still increments.
